// File: rtl/mips_tb_pkg.sv
// Shared types for the store monitor: FSM state encoding and status text.
// Latency: n/a (declarations only). Backpressure: n/a.
// Exports state_t and the five 40-bit ASCII status words (MSB = first char).
package mips_tb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_PASS  = 3'd2,
        ST_FAIL  = 3'd3,
        ST_TMOUT = 3'd4
    } state_t;

    localparam logic [39:0] ASCII_IDLE  = "IDLE ";
    localparam logic [39:0] ASCII_RUN   = "RUN  ";
    localparam logic [39:0] ASCII_PASS  = "PASS ";
    localparam logic [39:0] ASCII_FAIL  = "FAIL ";
    localparam logic [39:0] ASCII_TMOUT = "TMOUT";

endpackage

// File: rtl/status_ascii_enc.sv
// Maps a monitor state to its five-character status text.
// Latency: purely combinational; the parent registers the result. Backpressure: none.
// Ports: state_i (monitor state), ascii_o (40-bit text, MSB = first character).
module status_ascii_enc
    import mips_tb_pkg::*;
(
    input  state_t      state_i,
    output logic [39:0] ascii_o
);

    always_comb begin
        ascii_o = ASCII_IDLE;
        case (state_i)
            ST_IDLE:  ascii_o = ASCII_IDLE;
            ST_RUN:   ascii_o = ASCII_RUN;
            ST_PASS:  ascii_o = ASCII_PASS;
            ST_FAIL:  ascii_o = ASCII_FAIL;
            ST_TMOUT: ascii_o = ASCII_TMOUT;
            default:  ascii_o = ASCII_IDLE;
        endcase
    end

endmodule

// File: rtl/mem_store_monitor.sv
// Watches CPU data-memory stores and reaches a sticky pass/fail/timeout verdict.
// Latency: outputs are registered and reflect a sampled store right after that edge.
// Backpressure: none; the CPU bus is observed only, never stalled.
// Ports: clk, rst (sync active-low), en (start), memen/memwrite/dataadr/writedata
// (CPU store bus); done/pass/fail verdict flags, store_cnt (accepted stores,
// saturating), bad_addr (first offending address), ascii (status text).
module mem_store_monitor
    import mips_tb_pkg::*;
#(
    parameter logic [31:0] PASS_ADDR  = 32'd84,
    parameter logic [31:0] PASS_DATA  = 32'd7,
    parameter logic [31:0] ALLOW_ADDR = 32'd80,
    parameter logic [19:0] TIMEOUT    = 20'd100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        memen,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic [15:0] store_cnt,
    output logic [31:0] bad_addr,
    output logic [39:0] ascii
);

    state_t      state_q, state_d;
    logic [19:0] cyc_q, cyc_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] bad_q, bad_d;
    logic        done_q, pass_q, fail_q;
    logic        done_d, pass_d, fail_d;
    logic [39:0] ascii_q, ascii_d;
    logic        store_vld;

    assign store_vld = memen & memwrite;

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        cnt_d   = cnt_q;
        bad_d   = bad_q;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_RUN;
                    cyc_d   = '0;
                end
            end
            ST_RUN: begin
                cyc_d = cyc_q + 20'd1;
                // A store in the same cycle as the timeout wins over it.
                if (store_vld) begin
                    if (cnt_q != 16'hFFFF) begin
                        cnt_d = cnt_q + 16'd1;
                    end
                    if (dataadr == PASS_ADDR && writedata == PASS_DATA) begin
                        state_d = ST_PASS;
                    end else if (dataadr != ALLOW_ADDR) begin
                        state_d = ST_FAIL;
                        bad_d   = dataadr;
                    end
                end else if (cyc_q == TIMEOUT - 20'd1) begin
                    state_d = ST_TMOUT;
                end
            end
            default: ;  // verdict states hold until reset
        endcase
    end

    // Flags are decoded from the next state so the registered outputs line up
    // with the state register instead of lagging it by a cycle.
    always_comb begin
        done_d = (state_d == ST_PASS) || (state_d == ST_FAIL) || (state_d == ST_TMOUT);
        pass_d = (state_d == ST_PASS);
        fail_d = (state_d == ST_FAIL) || (state_d == ST_TMOUT);
    end

    status_ascii_enc u_enc (
        .state_i (state_d),
        .ascii_o (ascii_d)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cyc_q   <= '0;
            cnt_q   <= '0;
            bad_q   <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            ascii_q <= ASCII_IDLE;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            cnt_q   <= cnt_d;
            bad_q   <= bad_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            ascii_q <= ascii_d;
        end
    end

    assign done      = done_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign store_cnt = cnt_q;
    assign bad_addr  = bad_q;
    assign ascii     = ascii_q;

endmodule

// File: tb/tb_mem_store_monitor.sv
// Directed bench for mem_store_monitor (TIMEOUT shortened to 50 cycles).
// Latency: outputs sampled 1 ns after each rising edge. Backpressure: n/a.
// Inputs are changed just after an edge and take effect at the next edge.
module tb_mem_store_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        memen = 1'b0;
    logic        memwrite = 1'b0;
    logic [31:0] dataadr = '0;
    logic [31:0] writedata = '0;
    logic        done, pass, fail;
    logic [15:0] store_cnt;
    logic [31:0] bad_addr;
    logic [39:0] ascii;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_store_monitor #(
        .PASS_ADDR  (32'd84),
        .PASS_DATA  (32'd7),
        .ALLOW_ADDR (32'd80),
        .TIMEOUT    (20'd50)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .memen     (memen),
        .memwrite  (memwrite),
        .dataadr   (dataadr),
        .writedata (writedata),
        .done      (done),
        .pass      (pass),
        .fail      (fail),
        .store_cnt (store_cnt),
        .bad_addr  (bad_addr),
        .ascii     (ascii)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_store(input logic [31:0] a, input logic [31:0] d);
        memen     = 1'b1;
        memwrite  = 1'b1;
        dataadr   = a;
        writedata = d;
    endtask

    task automatic no_store();
        memen     = 1'b0;
        memwrite  = 1'b0;
        dataadr   = '0;
        writedata = '0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".done"},  done,      1'b0);
        chk({tag, ".pass"},  pass,      1'b0);
        chk({tag, ".fail"},  fail,      1'b0);
        chk({tag, ".cnt"},   store_cnt, 16'd0);
        chk({tag, ".bad"},   bad_addr,  32'd0);
        chk({tag, ".ascii"}, ascii,     "IDLE ");
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        en  = 1'b0;
        no_store();
        tick();
        chk_reset_vals(tag);
        rst = 1'b1;
    endtask

    task automatic start_run();
        en = 1'b1;
        tick();
        en = 1'b0;
    endtask

    initial begin
        // Power-on reset
        tick();
        do_reset("por");

        // Store while idle and disabled: ignored
        set_store(32'd84, 32'd7);
        tick();
        chk("idle_store.ascii", ascii, "IDLE ");
        chk("idle_store.cnt", store_cnt, 16'd0);
        chk("idle_store.pass", pass, 1'b0);
        no_store();

        // Allowed store then passing store
        start_run();
        chk("run.ascii", ascii, "RUN  ");
        chk("run.done", done, 1'b0);
        set_store(32'd80, 32'h1234);
        tick();
        chk("allow.cnt", store_cnt, 16'd1);
        chk("allow.ascii", ascii, "RUN  ");
        set_store(32'd84, 32'd7);
        tick();
        chk("pass.pass", pass, 1'b1);
        chk("pass.done", done, 1'b1);
        chk("pass.fail", fail, 1'b0);
        chk("pass.cnt", store_cnt, 16'd2);
        chk("pass.ascii", ascii, "PASS ");
        // Terminal: en and further stores have no effect
        en = 1'b1;
        set_store(32'd100, 32'd1);
        tick();
        chk("pass_hold.ascii", ascii, "PASS ");
        chk("pass_hold.cnt", store_cnt, 16'd2);
        chk("pass_hold.bad", bad_addr, 32'd0);
        do_reset("rst_pass");

        // Pass address with wrong data
        start_run();
        set_store(32'd84, 32'd6);
        tick();
        chk("wrongdata.fail", fail, 1'b1);
        chk("wrongdata.done", done, 1'b1);
        chk("wrongdata.pass", pass, 1'b0);
        chk("wrongdata.bad", bad_addr, 32'd84);
        chk("wrongdata.cnt", store_cnt, 16'd1);
        chk("wrongdata.ascii", ascii, "FAIL ");
        do_reset("rst_fail");

        // Two allowed stores then a bad address
        start_run();
        set_store(32'd80, 32'd1);
        tick();
        set_store(32'd80, 32'd2);
        tick();
        set_store(32'd100, 32'd7);
        tick();
        chk("badaddr.fail", fail, 1'b1);
        chk("badaddr.bad", bad_addr, 32'd100);
        chk("badaddr.cnt", store_cnt, 16'd3);
        chk("badaddr.ascii", ascii, "FAIL ");
        no_store();
        tick();
        chk("badaddr_hold.bad", bad_addr, 32'd100);
        do_reset("rst_bad");

        // Partial strobes are not stores
        start_run();
        memen = 1'b0; memwrite = 1'b1; dataadr = 32'd100; writedata = 32'd7;
        tick();
        chk("nomemen.cnt", store_cnt, 16'd0);
        chk("nomemen.fail", fail, 1'b0);
        memen = 1'b1; memwrite = 1'b0;
        tick();
        chk("nowrite.cnt", store_cnt, 16'd0);
        chk("nowrite.ascii", ascii, "RUN  ");

        // One-cycle reset mid-RUN drops everything
        set_store(32'd80, 32'd3);
        tick();
        chk("midrun.cnt", store_cnt, 16'd1);
        no_store();
        rst = 1'b0;
        tick();
        chk_reset_vals("midrun_rst");
        rst = 1'b1;
        tick();
        chk("midrun_after.ascii", ascii, "IDLE ");

        // Timeout: TMOUT on the 50th edge after entering RUN
        start_run();
        for (int i = 0; i < 49; i++) tick();
        chk("pre_tmout.ascii", ascii, "RUN  ");
        chk("pre_tmout.done", done, 1'b0);
        tick();
        chk("tmout.ascii", ascii, "TMOUT");
        chk("tmout.fail", fail, 1'b1);
        chk("tmout.done", done, 1'b1);
        chk("tmout.pass", pass, 1'b0);
        chk("tmout.bad", bad_addr, 32'd0);
        do_reset("rst_tmout");

        // Passing store on the timeout cycle wins
        start_run();
        for (int i = 0; i < 49; i++) tick();
        set_store(32'd84, 32'd7);
        tick();
        chk("last_cycle.pass", pass, 1'b1);
        chk("last_cycle.fail", fail, 1'b0);
        chk("last_cycle.cnt", store_cnt, 16'd1);
        chk("last_cycle.ascii", ascii, "PASS ");
        no_store();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
